// File: rtl/cpu_pkg.sv
// Shared constants for the tiny tensor core CPU.
// Opcodes, instruction field positions and default sizes.
package cpu_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int NUM_REGS    = 16;
  localparam int INSTR_WIDTH = 32;
  localparam int REG_AW      = 4;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RS1_HI = 19;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 12;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_OR   = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;
  localparam logic [7:0] OP_MUL  = 8'h07;
  localparam logic [7:0] OP_SHL  = 8'h08;
  localparam logic [7:0] OP_SHR  = 8'h09;
  localparam logic [7:0] OP_MOV  = 8'h0A;
  localparam logic [7:0] OP_OUT  = 8'h0B;
  localparam logic [7:0] OP_ADDI = 8'h0C;
  localparam logic [7:0] OP_MAC  = 8'h0D;

endpackage

// File: rtl/cpu_alu.sv
// Combinational execute unit for cpu_core.
// Produces the result, a register write-enable and an output-load flag.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [7:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] rd_val,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  we,
  output logic                  upd
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   prod_lo;

  // Low half of the product feeds both MUL and MAC
  always_comb begin
    prod    = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    prod_lo = prod[DATA_WIDTH-1:0];
  end

  // Opcode decode; unknown opcodes behave as NOP
  always_comb begin
    result = '0;
    we     = 1'b0;
    unique case (opcode)
      OP_LDI:  begin result = imm;            we = 1'b1; end
      OP_ADD:  begin result = a + b;          we = 1'b1; end
      OP_SUB:  begin result = a - b;          we = 1'b1; end
      OP_AND:  begin result = a & b;          we = 1'b1; end
      OP_OR:   begin result = a | b;          we = 1'b1; end
      OP_XOR:  begin result = a ^ b;          we = 1'b1; end
      OP_MUL:  begin result = prod_lo;        we = 1'b1; end
      OP_SHL:  begin result = a << b[2:0];    we = 1'b1; end
      OP_SHR:  begin result = a >> b[2:0];    we = 1'b1; end
      OP_MOV:  begin result = a;              we = 1'b1; end
      OP_OUT:  begin result = a;                         end
      OP_ADDI: begin result = a + imm;        we = 1'b1; end
      OP_MAC:  begin result = rd_val + prod_lo; we = 1'b1; end
      default: begin end
    endcase
  end

  // Output register loads on any write and on OUT
  always_comb upd = we | (opcode == OP_OUT);

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 8-bit register-machine CPU.
// Executes one externally supplied instruction per rising edge.
module cpu_core
  import cpu_pkg::*;
(
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic [INSTR_WIDTH-1:0] current_instruction,
  output logic [DATA_WIDTH-1:0]  cpu_output
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [7:0]            opcode;
  logic [REG_AW-1:0]     rd;
  logic [REG_AW-1:0]     rs1;
  logic [REG_AW-1:0]     rs2;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] result;
  logic                  we;
  logic                  upd;
  logic                  unused_bits;

  // Field split; bits 11:8 carry no meaning
  always_comb begin
    opcode      = current_instruction[OPC_HI:OPC_LO];
    rd          = current_instruction[RD_HI:RD_LO];
    rs1         = current_instruction[RS1_HI:RS1_LO];
    rs2         = current_instruction[RS2_HI:RS2_LO];
    imm         = current_instruction[IMM_HI:IMM_LO];
    unused_bits = ^current_instruction[11:8];
  end

  // Pre-edge register reads; r0 is never written so it reads 0
  always_comb begin
    a      = regs[rs1];
    b      = regs[rs2];
    rd_val = regs[rd];
  end

  cpu_alu u_alu (
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .rd_val (rd_val),
    .imm    (imm),
    .result (result),
    .we     (we),
    .upd    (upd)
  );

  // Register file and output register commit
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      cpu_output <= '0;
    end else begin
      if (we && rd != '0) regs[rd] <= result;
      if (upd) cpu_output <= result;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Randomised and directed bench for cpu_core.
// Compares against an arithmetic model of the instruction set.
module tb_cpu_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [7:0]  cpu_output;

  int total;
  int bad;

  int mreg [16];
  int mout;

  cpu_core dut (
    .clock_in            (clk),
    .reset_n_in          (rst_n),
    .current_instruction (instr),
    .cpu_output          (cpu_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(
    input int op, input int rd, input int s1,
    input int s2, input int imm);
    logic [31:0] w;
    w = '0;
    w[31:24] = 8'(op);
    w[23:20] = 4'(rd);
    w[19:16] = 4'(s1);
    w[15:12] = 4'(s2);
    w[7:0]   = 8'(imm);
    return w;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%02h want=%02h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 0;
    mout = 0;
  endtask

  task automatic model_exec(input logic [31:0] w);
    int op, rd, x, y, imm, r;
    bit wr;
    op  = int'(w[31:24]);
    rd  = int'(w[23:20]);
    x   = mreg[int'(w[19:16])];
    y   = mreg[int'(w[15:12])];
    imm = int'(w[7:0]);
    wr  = 1;
    r   = 0;
    case (op)
      1:  r = imm;
      2:  r = (x + y) % 256;
      3:  r = (x - y + 256) % 256;
      4:  r = x & y;
      5:  r = x | y;
      6:  r = x ^ y;
      7:  r = (x * y) % 256;
      8:  r = (x * (1 << (y % 8))) % 256;
      9:  r = x / (1 << (y % 8));
      10: r = x;
      12: r = (x + imm) % 256;
      13: r = (mreg[rd] + x * y) % 256;
      default: wr = 0;
    endcase
    if (wr) begin
      mout = r;
      if (rd != 0) mreg[rd] = r;
    end else if (op == 11) begin
      mout = x;
    end
  endtask

  task automatic step(input logic [31:0] w, input bit lit_en,
                      input int lit, input string nm);
    @(negedge clk);
    instr = w;
    model_exec(w);
    @(posedge clk);
    #1;
    chk("model", int'(cpu_output), mout);
    if (lit_en) begin
      chk(nm, int'(cpu_output), lit);
      chk({nm, "_ref"}, mout, lit);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    instr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset", int'(cpu_output), 0);
    @(negedge clk);
    rst_n = 1'b1;

    step(mk(11, 0, 5, 0, 0),    1, 8'h00, "out_r5");
    step(mk(1, 1, 0, 0, 8'h7F), 1, 8'h7F, "ldi1");
    step(mk(1, 2, 0, 0, 8'h02), 1, 8'h02, "ldi2");
    step(mk(2, 3, 1, 2, 0),     1, 8'h81, "add");
    step(mk(11, 0, 3, 0, 0),    1, 8'h81, "out_r3");
    step(mk(1, 1, 0, 0, 8'hFF), 1, 8'hFF, "ldi_ff");
    step(mk(12, 2, 1, 0, 3),    1, 8'h02, "addi_wrap");
    step(mk(3, 3, 0, 1, 0),     1, 8'h01, "sub_wrap");
    step(mk(1, 5, 0, 0, 8'h10), 1, 8'h10, "ldi10");
    step(mk(7, 6, 5, 5, 0),     1, 8'h00, "mul_wrap");
    step(mk(1, 1, 0, 0, 8'h96), 1, 8'h96, "ldi96");
    step(mk(1, 2, 0, 0, 8'h03), 1, 8'h03, "ldi3");
    step(mk(8, 3, 1, 2, 0),     1, 8'hB0, "shl");
    step(mk(9, 3, 1, 2, 0),     1, 8'h12, "shr");
    step(mk(6, 4, 1, 1, 0),     1, 8'h00, "xor");
    step(mk(1, 2, 0, 0, 8'h0F), 1, 8'h0F, "ldi0f");
    step(mk(4, 3, 1, 2, 0),     1, 8'h06, "and");
    step(mk(1, 4, 0, 0, 8'h05), 1, 8'h05, "ldi5");
    step(mk(1, 1, 0, 0, 8'h03), 1, 8'h03, "ldi3b");
    step(mk(1, 2, 0, 0, 8'h04), 1, 8'h04, "ldi4");
    step(mk(13, 4, 1, 2, 0),    1, 8'h11, "mac");
    step(mk(2, 1, 1, 1, 0),     1, 8'h06, "add_self");
    step(mk(1, 0, 0, 0, 8'h55), 1, 8'h55, "ldi_r0");
    step(mk(11, 0, 0, 0, 0),    1, 8'h00, "out_r0");
    step(mk(11, 0, 4, 0, 0),    1, 8'h11, "out_r4");
    step(32'hFF123456,          1, 8'h11, "undef");
    step(mk(0, 4, 1, 2, 8'hAA), 1, 8'h11, "nop");

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", int'(cpu_output), 0);
    model_reset();
    @(negedge clk);
    instr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(11, 0, 4, 0, 0),    1, 8'h00, "post_rst");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      int op;
      w  = $urandom;
      op = int'($urandom_range(0, 16));
      if (op == 16) op = 8'hF0 + int'($urandom_range(0, 15));
      w[31:24] = 8'(op);
      step(w, 0, 0, "");
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst2", int'(cpu_output), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 16; i++) step(mk(11, 0, i, 0, 0), 0, 0, "");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
